pwm_peripheral: RTL

//   Consumes the five configuration registers written by spi_peripheral and drives 16 outputs.

---
 rtl/pwm_peripheral.sv | 70 +++++++
 1 files changed

// File: rtl/pwm_peripheral.sv
// PWM output stage: prescaled 8-bit period counter, double-buffered duty,
// per-output force-low / static-high / PWM selection with registered outputs.
module pwm_peripheral #(
   parameter int unsigned PRESCALE = 3000,
   parameter int unsigned PRE_W    = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] pwm_out,
   output logic        period_start
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned OUT_W = 16;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [CNT_W-1:0] duty_act_q, duty_act_d;
   logic [OUT_W-1:0] pwm_out_q, pwm_out_d;
   logic             period_start_q, period_start_d;

   logic             tick_c;
   logic             pwm_lvl_c;
   logic [OUT_W-1:0] en_out_c;
   logic [OUT_W-1:0] en_pwm_c;

   // Next-state: prescaler, period counter, duty buffer, output mux
   always_comb begin
      tick_c         = (pre_cnt_q == PRE_LAST);
      pre_cnt_d      = tick_c ? '0 : pre_cnt_q + PRE_W'(1);
      pwm_cnt_d      = tick_c ? pwm_cnt_q + CNT_W'(1) : pwm_cnt_q;
      // New duty only at the wrap to 0 so a period is never cut short
      duty_act_d     = (tick_c && (pwm_cnt_q == CNT_LAST)) ? pwm_duty_cycle : duty_act_q;
      // Full-scale duty bypasses the compare so there is no dip at count 255
      pwm_lvl_c      = (duty_act_q == CNT_LAST) ? 1'b1 : (pwm_cnt_q < duty_act_q);
      en_out_c       = {en_reg_out_15_8, en_reg_out_7_0};
      en_pwm_c       = {en_reg_pwm_15_8, en_reg_pwm_7_0};
      pwm_out_d      = en_out_c & (~en_pwm_c | {OUT_W{pwm_lvl_c}});
      // First clk of count 0 is the only one where the prescaler is also at 0
      period_start_d = (pwm_cnt_q == '0) && (pre_cnt_q == '0);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt_q      <= '0;
         pwm_cnt_q      <= '0;
         duty_act_q     <= '0;
         pwm_out_q      <= '0;
         period_start_q <= 1'b0;
      end else begin
         pre_cnt_q      <= pre_cnt_d;
         pwm_cnt_q      <= pwm_cnt_d;
         duty_act_q     <= duty_act_d;
         pwm_out_q      <= pwm_out_d;
         period_start_q <= period_start_d;
      end
   end

   assign pwm_out      = pwm_out_q;
   assign period_start = period_start_q;

endmodule
